// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesting blocks and the arbiter.
// Signal prefixes are from the arbiter's point of view: i_ enters it, o_ leaves it.
interface decoder_rr_arbiter_if #(
   parameter int N     = 4,
   parameter int IDX_W = 2
);
   logic             i_en;
   logic [N-1:0]     i_req;
   logic             i_done;
   logic [N-1:0]     o_gnt;
   logic [IDX_W-1:0] o_gnt_idx;
   logic             o_gnt_valid;
   logic             o_timeout;

   // Requester side: drives requests, observes the grant.
   modport master (
      output i_en, i_req, i_done,
      input  o_gnt, o_gnt_idx, o_gnt_valid, o_timeout
   );

   // Arbiter side.
   modport slave (
      input  i_en, i_req, i_done,
      output o_gnt, o_gnt_idx, o_gnt_valid, o_timeout
   );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for one shared, decoder-selected resource.
// A registered owner index is decoded to a one-hot enable. Every ownership
// change passes through a one-cycle dead state, so two enables are never
// active together. A hold watchdog force-releases owners that never finish.
module decoder_rr_arbiter #(
   parameter int N        = 4,
   parameter int IDX_W    = 2,   // must equal $clog2(N)
   parameter int MAX_HOLD = 15   // 1..255
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   decoder_rr_arbiter_if.slave   s_bus
);

   localparam int HCNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   // Registered state and outputs.
   state_t             r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [HCNT_W-1:0]  r_hcnt;
   logic [N-1:0]       r_gnt;
   logic [IDX_W-1:0]   r_gnt_idx;
   logic               r_gnt_valid;
   logic               r_timeout;

   // Next-state values.
   state_t             w_state_next;
   logic [IDX_W-1:0]   w_ptr_next;
   logic [HCNT_W-1:0]  w_hcnt_next;
   logic [N-1:0]       w_gnt_next;
   logic [IDX_W-1:0]   w_gnt_idx_next;
   logic               w_gnt_valid_next;
   logic               w_timeout_next;

   // Arbitration helpers.
   logic               w_found;
   logic [IDX_W-1:0]   w_winner;
   logic [N-1:0]       w_winner_dec;
   logic [N-1:0]       w_owner_sel;
   logic               w_owner_req;
   logic [IDX_W-1:0]   w_owner_inc;
   logic               w_hold_expired;

   // Search upward from the pointer, wrapping at N-1, for the first requester.
   // The rotated index is reduced with a compare-and-subtract, so non-power-of-two N
   // never produces an index of N or above.
   always_comb begin
      int v_idx;
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = 0;
      for (int k = 0; k < N; k++) begin
         v_idx = int'(r_ptr) + k;
         if (v_idx >= N) begin
            v_idx = v_idx - N;
         end
         if (!w_found && s_bus.i_req[v_idx]) begin
            w_found  = 1'b1;
            w_winner = IDX_W'(v_idx);
         end
      end
   end

   // One-hot decode of the winner. Also pick out the owner's own request bit
   // using the registered one-hot grant, so other requesters' bits are ignored.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_decode
         assign w_winner_dec[gi] = (w_winner == IDX_W'(gi));
         assign w_owner_sel[gi]  = r_gnt[gi] & s_bus.i_req[gi];
      end
   endgenerate

   assign w_owner_req    = |w_owner_sel;
   assign w_owner_inc    = (r_gnt_idx == IDX_W'(N - 1)) ? '0 : (r_gnt_idx + IDX_W'(1));
   assign w_hold_expired = (r_hcnt == HCNT_W'(MAX_HOLD - 1));

   // Next-state and next-output logic. Outputs default to idle (all zero) and
   // only the GRANT path keeps them alive, so leaving GRANT clears the enable.
   always_comb begin
      w_state_next     = r_state;
      w_ptr_next       = r_ptr;
      w_hcnt_next      = r_hcnt;
      w_gnt_next       = '0;
      w_gnt_idx_next   = '0;
      w_gnt_valid_next = 1'b0;
      w_timeout_next   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (s_bus.i_en && w_found) begin
               w_state_next     = ST_GRANT;
               w_gnt_next       = w_winner_dec;
               w_gnt_idx_next   = w_winner;
               w_gnt_valid_next = 1'b1;
               w_hcnt_next      = '0;
            end
         end

         ST_GRANT: begin
            // Release priority: DONE, then owner dropping its request, then
            // the watchdog. TIMEOUT only flags a purely watchdog-driven release.
            if (s_bus.i_done || !w_owner_req || w_hold_expired) begin
               w_state_next   = ST_RELEASE;
               w_ptr_next     = w_owner_inc;
               w_timeout_next = !s_bus.i_done && w_owner_req;
            end else begin
               // EN is deliberately not consulted: an active grant is not revoked.
               w_gnt_next       = r_gnt;
               w_gnt_idx_next   = r_gnt_idx;
               w_gnt_valid_next = 1'b1;
               if (r_hcnt != HCNT_W'(MAX_HOLD)) begin
                  w_hcnt_next = r_hcnt + HCNT_W'(1);
               end
            end
         end

         ST_RELEASE: begin
            // Break-before-make dead cycle; no arbitration here.
            w_state_next = ST_IDLE;
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears the grant without waiting for a clock.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_hcnt      <= '0;
         r_gnt       <= '0;
         r_gnt_idx   <= '0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_ptr       <= w_ptr_next;
         r_hcnt      <= w_hcnt_next;
         r_gnt       <= w_gnt_next;
         r_gnt_idx   <= w_gnt_idx_next;
         r_gnt_valid <= w_gnt_valid_next;
         r_timeout   <= w_timeout_next;
      end
   end

   assign s_bus.o_gnt       = r_gnt;
   assign s_bus.o_gnt_idx   = r_gnt_idx;
   assign s_bus.o_gnt_valid = r_gnt_valid;
   assign s_bus.o_timeout   = r_timeout;

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares one decoder-selected resource among N requesters.
- Sequences a registered grant index through a one-hot decode stage, gated by a grant-valid enable, with break-before-make between owners and a hold-timeout watchdog.
- Sits between requesting blocks and the shared datapath.
- GNT is the enable vector for the shared resource; GNT_IDX drives the resource select.

Parameters:
- N, 4: number of requesters, legal range 2..16.
- IDX_W, 2: width of GNT_IDX; must equal ceil(log2(N)).
- MAX_HOLD, 15: maximum cycles a grant is held before forced release; legal range 1..255.

Ports:
- CLK  input  1: single clock; all state changes on the rising edge.
- RST_N  input  1: asynchronous, active-low reset.
- EN  input  1: arbitration enable; when low, no new grant is issued.
- REQ  input  N: request vector; bit i is held high by requester i while it wants or uses the resource.
- DONE  input  1: single-cycle pulse from the current owner marking end of transaction.
- GNT  output  N: one-hot grant; all zero when GNT_VALID is 0.
- GNT_IDX  output  IDX_W: binary index of the current owner; 0 when idle.
- GNT_VALID  output  1: high while a grant is active.
- TIMEOUT  output  1: single-cycle pulse when a grant is force-released by the watchdog.

Behaviour:
- All outputs are registered; no combinational path from any input to any output.
- Reset (RST_N low, asynchronous):
  - GNT=0, GNT_IDX=0, GNT_VALID=0, TIMEOUT=0.
  - Priority pointer PTR=0, hold counter HCNT=0, state IDLE.
  - Reset asserted mid-grant clears GNT immediately, without waiting for a clock edge.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If EN=1 and REQ!=0, select the first set REQ bit searching upward from PTR, wrapping N-1 -> 0.
  - Next edge: GNT_IDX=winner, GNT=one-hot(winner), GNT_VALID=1, HCNT=0, state GRANT.
  - Latency: REQ sampled at edge t, GNT visible after edge t+1.
  - If EN=0 or REQ=0, remain in IDLE with outputs 0.
- GRANT:
  - HCNT increments every cycle, saturating at MAX_HOLD.
  - Release condition, evaluated each edge, in priority order:
    - (a) DONE=1
    - (b) REQ[GNT_IDX]=0
    - (c) HCNT==MAX_HOLD-1, i.e. the grant has been held MAX_HOLD cycles
  - On release: GNT=0, GNT_VALID=0, GNT_IDX=0, PTR=(owner+1) mod N, state RELEASE.
  - TIMEOUT pulses for exactly one cycle, coincident with the first RELEASE cycle, only when (c) causes the release and neither (a) nor (b) holds.
  - EN going low during GRANT does not revoke the current grant.
  - REQ changes on non-owner bits are ignored.
- RELEASE:
  - Exactly one dead cycle with GNT=0 (break-before-make), then state IDLE.
  - No arbitration is performed in this cycle.
  - Minimum spacing between two grants is therefore 2 idle cycles: RELEASE plus the IDLE decision.
- DONE outside GRANT is ignored.
- GNT is never more than one-hot; indices >= N are never granted.
- PTR wraps from N-1 to 0.
- A requester that keeps REQ high after its release is served again only after every other pending requester has had one turn.

Test Plan:
- Reset, then REQ=4'b0000, EN=1 for 10 cycles -> GNT=0, GNT_VALID=0, TIMEOUT=0 throughout. Assert RST_N low mid-grant -> GNT=0 asynchronously, PTR back to 0.
- REQ=4'b0100 at edge t, EN=1 -> GNT=4'b0100, GNT_IDX=2, GNT_VALID=1 after edge t+1. DONE pulse at edge t+4 -> GNT=0 after t+5, GNT re-asserted no earlier than after t+7.
- REQ=4'b1111 held, DONE after 2 grant cycles each time -> grant order 0,1,2,3,0, with one zero-GNT RELEASE cycle between each pair.
- REQ=4'b0001 held, no DONE, MAX_HOLD=15 -> GNT_VALID high for exactly 15 cycles, TIMEOUT one-cycle pulse on the release cycle, re-grant to 0 afterwards. Repeat with DONE on the 15th cycle -> no TIMEOUT pulse.
- Owner 1 granted with REQ=4'b0010, then EN=0 -> grant retained until DONE. With EN still 0 and REQ=4'b1010 -> no new grant. EN=1 -> GNT=4'b1000, since PTR=2 selects index 3 first.
- N=3, IDX_W=2, REQ=3'b111 held, DONE each grant -> GNT_IDX cycles 0,1,2,0, never 3; GNT remains one-hot or zero every cycle (assertion).
